// File: rtl/la_pkg.sv
// ---------------------------------------------------------------------------
// la_pkg
// Shared constants and encodings for the logic-analyser capture front end:
//   LA_CH          number of probe channels
//   LA_DEPTH_LOG2  default ring depth exponent (display RAM is 1024 x 8)
//   la_state_e     capture FSM states
//   TM_*           2-bit per-channel trigger condition codes
//   is_capturing() true in the states that write samples into the ring
// ---------------------------------------------------------------------------
package la_pkg;

    localparam int LA_CH         = 8;
    localparam int LA_DEPTH_LOG2 = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_HOLD  = 3'd4
    } la_state_e;

    localparam logic [1:0] TM_IGNORE = 2'b00;
    localparam logic [1:0] TM_HIGH   = 2'b01;
    localparam logic [1:0] TM_RISE   = 2'b10;
    localparam logic [1:0] TM_FALL   = 2'b11;

    function automatic logic is_capturing(input la_state_e s);
        return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/la_trig_match.sv
// ---------------------------------------------------------------------------
// la_trig_match
// Combinational trigger evaluation. Each channel is checked against its
// 2-bit mode; the trigger fires only when every channel is satisfied, so
// ignored channels count as satisfied and an all-ignore mode always hits.
// Ports:
//   sample    in  LA_CH     current tick's synchronised sample
//   prev      in  LA_CH     previous tick's sample
//   prev_vld  in  1         prev holds a real sample (edges are false if not)
//   trig_mode in  2*LA_CH   per-channel mode, channel i at [2i+1:2i]
//   hit       out 1         all channel conditions met
// ---------------------------------------------------------------------------
module la_trig_match
    import la_pkg::*;
(
    input  logic [LA_CH-1:0]   sample,
    input  logic [LA_CH-1:0]   prev,
    input  logic               prev_vld,
    input  logic [2*LA_CH-1:0] trig_mode,
    output logic               hit
);

    logic [LA_CH-1:0] ch_ok;

    always_comb begin
        ch_ok = '0;
        for (int i = 0; i < LA_CH; i++) begin
            case (trig_mode[2*i +: 2])
                TM_IGNORE: ch_ok[i] = 1'b1;
                TM_HIGH:   ch_ok[i] = sample[i];
                TM_RISE:   ch_ok[i] = prev_vld & ~prev[i] & sample[i];
                TM_FALL:   ch_ok[i] = prev_vld & prev[i] & ~sample[i];
                default:   ch_ok[i] = 1'b0;
            endcase
        end
    end

    assign hit = &ch_ok;

endmodule

// File: rtl/la_capture_trigger.sv
// ---------------------------------------------------------------------------
// la_capture_trigger
// Logic-analyser capture front end. Probes are synchronised, sampled every
// div+1 pclk cycles and written into a ring; after the trigger the frame is
// completed so that the ring holds exactly 2**DEPTH_LOG2 samples with the
// trigger at index pre_len, then the frame is held for HOLD_CYCLES before
// re-arming (continuous) or returning to IDLE.
// Optional feature: define LA_AUTO_TRIG_EN to force a trigger after
// AUTO_TIMEOUT sample ticks in ARMED; adds the auto_fired output.
// Ports:
//   pclk, rst_n       clock, synchronous active-low reset
//   la_in             asynchronous probe inputs
//   arm / stop        1-cycle start / abort pulses (stop wins)
//   continuous        re-arm after HOLD when 1
//   div, pre_len, trig_mode   capture configuration, latched on arm
//   wr_data/wr_en/wr_addr     ring write port toward the display RAM
//   start_addr        last sample address of the most recent frame
//   trigger_en        1 while capturing (display suppresses drawing)
//   triggered         pulses with the write of the trigger sample
//   auto_fired        (LA_AUTO_TRIG_EN) pulses with a forced trigger
//   busy              FSM not in IDLE
// ---------------------------------------------------------------------------
module la_capture_trigger
    import la_pkg::*;
#(
    parameter int DEPTH_LOG2  = LA_DEPTH_LOG2,
    parameter int HOLD_CYCLES = 2_000_000
`ifdef LA_AUTO_TRIG_EN
    ,
    parameter int AUTO_TIMEOUT = 1_000_000
`endif
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic [LA_CH-1:0]      la_in,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [15:0]           div,
    input  logic [DEPTH_LOG2-1:0] pre_len,
    input  logic [2*LA_CH-1:0]    trig_mode,
    output logic [LA_CH-1:0]      wr_data,
    output logic                  wr_en,
    output logic [DEPTH_LOG2-1:0] wr_addr,
    output logic [DEPTH_LOG2-1:0] start_addr,
    output logic                  trigger_en,
    output logic                  triggered,
`ifdef LA_AUTO_TRIG_EN
    output logic                  auto_fired,
`endif
    output logic                  busy
);

    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
`ifdef LA_AUTO_TRIG_EN
    localparam int AUTO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
`endif

    la_state_e             state_q, state_d;
    logic [15:0]           div_cnt_q, div_cnt_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [DEPTH_LOG2-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]      post_cnt_q, post_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                  prev_vld_q, prev_vld_d;
    logic                  wr_en_q, wr_en_d;
    logic [LA_CH-1:0]      wr_data_q, wr_data_d;
    logic [DEPTH_LOG2-1:0] wr_addr_q, wr_addr_d;
    logic [DEPTH_LOG2-1:0] start_addr_q, start_addr_d;
    logic                  trigger_en_q, trigger_en_d;
    logic                  triggered_q, triggered_d;
`ifdef LA_AUTO_TRIG_EN
    logic [AUTO_W-1:0]     auto_cnt_q, auto_cnt_d;
    logic                  auto_fired_q, auto_fired_d;
`endif

    // Datapath registers: no reset needed, only consumed once the FSM is active.
    logic [LA_CH-1:0]      sync1_q, sync2_q;
    logic [LA_CH-1:0]      prev_q, prev_d;
    logic [15:0]           div_cfg_q, div_cfg_d;
    logic [DEPTH_LOG2-1:0] pre_len_q, pre_len_d;
    logic [2*LA_CH-1:0]    trig_mode_q, trig_mode_d;

    logic             tick, hit, fire;
    logic [CNT_W-1:0] post_len;

    la_trig_match u_match (
        .sample    (sync2_q),
        .prev      (prev_q),
        .prev_vld  (prev_vld_q),
        .trig_mode (trig_mode_q),
        .hit       (hit)
    );

    assign tick     = is_capturing(state_q) && (div_cnt_q == div_cfg_q);
    // pre_len is DEPTH_LOG2 bits wide, so it can never exceed DEPTH-1 and
    // at least the trigger sample always lands in POST.
    assign post_len = DEPTH_CNT - CNT_W'(pre_len_q);

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = is_capturing(state_q) ? div_cnt_q + 16'd1 : 16'd0;
        ptr_d        = ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        prev_vld_d   = prev_vld_q;
        prev_d       = prev_q;
        div_cfg_d    = div_cfg_q;
        pre_len_d    = pre_len_q;
        trig_mode_d  = trig_mode_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        wr_addr_d    = wr_addr_q;
        start_addr_d = start_addr_q;
        trigger_en_d = is_capturing(state_q);
        triggered_d  = 1'b0;
        fire         = 1'b0;
`ifdef LA_AUTO_TRIG_EN
        auto_cnt_d   = (state_q == ST_ARMED) ? auto_cnt_q : '0;
        auto_fired_d = 1'b0;
`endif

        // Every tick writes the sample at ptr and then advances the ring.
        if (tick) begin
            div_cnt_d  = 16'd0;
            wr_en_d    = 1'b1;
            wr_data_d  = sync2_q;
            wr_addr_d  = ptr_q;
            ptr_d      = ptr_q + DEPTH_LOG2'(1);
            prev_d     = sync2_q;
            prev_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    div_cfg_d   = div;
                    pre_len_d   = pre_len;
                    trig_mode_d = trig_mode;
                    pre_cnt_d   = '0;
                    prev_vld_d  = 1'b0;
                    state_d     = (pre_len == '0) ? ST_ARMED : ST_PRE;
                end
            end
            ST_PRE: begin
                if (tick) begin
                    pre_cnt_d = pre_cnt_q + DEPTH_LOG2'(1);
                    if (pre_cnt_d == pre_len_q) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (tick) begin
                    fire = hit;
`ifdef LA_AUTO_TRIG_EN
                    auto_cnt_d = auto_cnt_q + AUTO_W'(1);
                    if (!hit && (auto_cnt_q == AUTO_W'(AUTO_TIMEOUT - 1))) begin
                        fire         = 1'b1;
                        auto_fired_d = 1'b1;
                    end
`endif
                    if (fire) begin
                        triggered_d = 1'b1;
                        post_cnt_d  = CNT_W'(1);
                        if (post_len == CNT_W'(1)) begin
                            state_d      = ST_HOLD;
                            start_addr_d = ptr_q;
                            hold_cnt_d   = '0;
                        end else begin
                            state_d = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (tick) begin
                    post_cnt_d = post_cnt_q + CNT_W'(1);
                    if (post_cnt_d == post_len) begin
                        state_d      = ST_HOLD;
                        start_addr_d = ptr_q;
                        hold_cnt_d   = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    if (continuous) begin
                        pre_cnt_d  = '0;
                        prev_vld_d = 1'b0;
                        state_d    = (pre_len_q == '0) ? ST_ARMED : ST_PRE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a write due on this cycle.
        if (stop) begin
            state_d      = ST_IDLE;
            wr_en_d      = 1'b0;
            wr_data_d    = wr_data_q;
            wr_addr_d    = wr_addr_q;
            ptr_d        = ptr_q;
            start_addr_d = start_addr_q;
            triggered_d  = 1'b0;
`ifdef LA_AUTO_TRIG_EN
            auto_fired_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            ptr_q        <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            prev_vld_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            start_addr_q <= '0;
            trigger_en_q <= 1'b0;
            triggered_q  <= 1'b0;
`ifdef LA_AUTO_TRIG_EN
            auto_cnt_q   <= '0;
            auto_fired_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            ptr_q        <= ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            prev_vld_q   <= prev_vld_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            start_addr_q <= start_addr_d;
            trigger_en_q <= trigger_en_d;
            triggered_q  <= triggered_d;
`ifdef LA_AUTO_TRIG_EN
            auto_cnt_q   <= auto_cnt_d;
            auto_fired_q <= auto_fired_d;
`endif
        end
    end

    // Two-flop synchroniser on the asynchronous probes, plus config/prev storage.
    always_ff @(posedge pclk) begin
        sync1_q     <= la_in;
        sync2_q     <= sync1_q;
        prev_q      <= prev_d;
        div_cfg_q   <= div_cfg_d;
        pre_len_q   <= pre_len_d;
        trig_mode_q <= trig_mode_d;
    end

    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign wr_addr    = wr_addr_q;
    assign start_addr = start_addr_q;
    assign trigger_en = trigger_en_q;
    assign triggered  = triggered_q;
    assign busy       = (state_q != ST_IDLE);
`ifdef LA_AUTO_TRIG_EN
    assign auto_fired = auto_fired_q;
`endif

endmodule

// File: tb/tb_la_capture_trigger.sv
`timescale 1ns/1ps
module tb_la_capture_trigger;
    import la_pkg::*;

    localparam int HOLD = 16;
`ifdef LA_AUTO_TRIG_EN
    localparam int AUTO_TO = 50;
`endif

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  la_in = 8'h00;
    logic [15:0] div = 16'd0;
    logic [9:0]  pre_len = 10'd0;
    logic [15:0] trig_mode = 16'd0;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [9:0]  start_addr;
    logic        trigger_en;
    logic        triggered;
    logic        busy;
    logic        auto_obs;

`ifdef LA_AUTO_TRIG_EN
    logic auto_fired;
    assign auto_obs = auto_fired;
`else
    assign auto_obs = 1'b0;
`endif

    la_capture_trigger #(
        .DEPTH_LOG2  (10),
        .HOLD_CYCLES (HOLD)
`ifdef LA_AUTO_TRIG_EN
        ,
        .AUTO_TIMEOUT (AUTO_TO)
`endif
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .la_in      (la_in),
        .arm        (arm),
        .stop       (stop),
        .continuous (continuous),
        .div        (div),
        .pre_len    (pre_len),
        .trig_mode  (trig_mode),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .start_addr (start_addr),
        .trigger_en (trigger_en),
        .triggered  (triggered),
`ifdef LA_AUTO_TRIG_EN
        .auto_fired (auto_fired),
`endif
        .busy       (busy)
    );

    always #5 pclk = ~pclk;

    // One expected ring write: gap==0 means the spacing to the previous write is not checked.
    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
        logic       trig;
        logic       autof;
        logic [7:0] gap;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_wr_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (rst_n && wr_en) begin
            wr_t e;
            wr_t got;
            int  gap;
            gap = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
            chk("wr_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got.addr  = wr_addr;
                got.data  = wr_data;
                got.trig  = triggered;
                got.autof = auto_obs;
                got.gap   = (e.gap == 8'd0) ? 8'd0 : 8'(gap);
                chk("wr_sample", 64'(got), 64'(e));
            end
        end
    end

    task automatic push_frame(input int n, input int addr0, input int trig_idx, input logic autof,
                              input int gap0, input int gap, input logic [7:0] d_lo,
                              input logic [7:0] d_hi, input int hi_from);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr  = 10'((addr0 + i) % 1024);
            e.data  = (i >= hi_from) ? d_hi : d_lo;
            e.trig  = (i == trig_idx);
            e.autof = autof && (i == trig_idx);
            e.gap   = (i == 0) ? 8'(gap0) : 8'(gap);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_arm(input logic [15:0] d, input logic [9:0] pl, input logic [15:0] tm,
                          input logic cont);
        @(negedge pclk);
        div = d; pre_len = pl; trig_mode = tm; continuous = cont; arm = 1'b1;
        @(negedge pclk);
        arm = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge pclk);
            n++;
        end
        chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        logic a1;

        // Reset values
        repeat (3) @(negedge pclk);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_start_addr", 64'(start_addr), 64'd0);
        chk("rst_trigger_en", 64'(trigger_en), 64'd0);
        chk("rst_triggered", 64'(triggered), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // pre_len=0, all channels ignored: trigger on the very first tick
        la_in = 8'hA5;
        repeat (3) @(negedge pclk);
        push_frame(1024, 0, 0, 1'b0, 0, 1, 8'hA5, 8'hA5, 0);
        do_arm(16'd0, 10'd0, 16'h0000, 1'b0);
        chk("t2_busy", 64'(busy), 64'd1);
        wait_drain("t2", 1100);
        chk("t2_start_addr", 64'(start_addr), 64'd1023);
        @(negedge pclk);
        chk("t2_trigger_en_hold", 64'(trigger_en), 64'd0);
        repeat (HOLD + 2) @(negedge pclk);
        chk("t2_idle", 64'(busy), 64'd0);

        // ch0 rising at tick 300, pre_len=100
        t1 = 300;
        a1 = 1'b0;
`ifdef LA_AUTO_TRIG_EN
        if (100 + AUTO_TO - 1 < 300) begin
            t1 = 100 + AUTO_TO - 1;
            a1 = 1'b1;
        end
`endif
        la_in = 8'h00;
        repeat (3) @(negedge pclk);
        push_frame(t1 + 924, 0, t1, a1, 0, 1, 8'h00, 8'h01, 300);
        do_arm(16'd0, 10'd100, 16'h0002, 1'b0);
        repeat (298) @(negedge pclk);
        la_in = 8'h01;
        chk("t1_trigger_en_active", 64'(trigger_en), 64'd1);
        wait_drain("t1", 1300);
        chk("t1_start_addr", 64'((t1 + 923) % 1024), 64'(start_addr));
        @(negedge pclk);
        chk("t1_trigger_en_after", 64'(trigger_en), 64'd0);
        repeat (HOLD + 2) @(negedge pclk);
        chk("t1_idle", 64'(busy), 64'd0);

        // div=3: one write every 4 cycles, ring wraps 1023->0 while in PRE
        la_in = 8'h3C;
        repeat (3) @(negedge pclk);
        push_frame(1024, 200, 1000, 1'b0, 0, 4, 8'h3C, 8'h3C, 0);
        do_arm(16'd3, 10'd1000, 16'h0000, 1'b0);
        wait_drain("t3", 4300);
        chk("t3_start_addr", 64'(start_addr), 64'd199);
        repeat (HOLD + 3) @(negedge pclk);
        chk("t3_idle", 64'(busy), 64'd0);

        // stop during POST: 21 writes (trigger at index 10), then nothing more
        la_in = 8'h02;
        repeat (3) @(negedge pclk);
        push_frame(21, 200, 10, 1'b0, 0, 1, 8'h02, 8'h02, 0);
        do_arm(16'd0, 10'd10, 16'h0004, 1'b0);
        repeat (21) @(negedge pclk);
        stop = 1'b1;
        @(negedge pclk);
        stop = 1'b0;
        chk("t4_busy_after_stop", 64'(busy), 64'd0);
        chk("t4_start_addr_kept", 64'(start_addr), 64'd199);
        repeat (3) @(negedge pclk);
        chk("t4_trigger_en", 64'(trigger_en), 64'd0);
        repeat (20) @(negedge pclk);
        chk("t4_queue", 64'(exp_q.size()), 64'd0);

        // continuous re-arm after HOLD; an arm while busy must be ignored
        la_in = 8'h5A;
        repeat (3) @(negedge pclk);
        push_frame(1024, 221, 4, 1'b0, 0, 1, 8'h5A, 8'h5A, 0);
        push_frame(1024, 221, 4, 1'b0, HOLD + 1, 1, 8'h5A, 8'h5A, 0);
        do_arm(16'd0, 10'd4, 16'h0000, 1'b1);
        repeat (2) @(negedge pclk);
        do_arm(16'd5, 10'd0, 16'hFFFF, 1'b1);
        chk("t5_busy", 64'(busy), 64'd1);
        wait_drain("t5", 2200);
        chk("t5_start_addr", 64'(start_addr), 64'd220);
        stop = 1'b1;
        @(negedge pclk);
        stop = 1'b0;
        continuous = 1'b0;
        chk("t5_busy_after_stop", 64'(busy), 64'd0);
        repeat (HOLD + 5) @(negedge pclk);
        chk("t5_queue", 64'(exp_q.size()), 64'd0);

`ifdef LA_AUTO_TRIG_EN
        // unmet condition: forced trigger on the 50th ARMED tick
        la_in = 8'h00;
        repeat (3) @(negedge pclk);
        push_frame(1024, 221, AUTO_TO - 1, 1'b1, 0, 1, 8'h00, 8'h00, 0);
        do_arm(16'd0, 10'd0, 16'h0010, 1'b0);
        wait_drain("t6", 1100);
        chk("t6_start_addr", 64'(start_addr), 64'd220);
        repeat (HOLD + 3) @(negedge pclk);
        chk("t6_idle", 64'(busy), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
